// File: rtl/dense_pkg.sv
// dense_pkg: shared FSM states, accumulator sizing and signed saturation for dense_layer
package dense_pkg;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    function automatic int acc_width(input int in_w, input int w_w, input int in_dim);
        return in_w + w_w + $clog2(in_dim + 1) + 1;
    endfunction

    // Widths are fixed at 128 bits so one function serves every OUT_W; callers truncate.
    function automatic logic signed [127:0] saturate(input logic signed [127:0] v, input int w);
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo = -hi - 128'sd1;
        return v > hi ? hi : v < lo ? lo : v;
    endfunction

endpackage

// File: rtl/dense_mac.sv
// dense_mac: one signed multiply-accumulate step plus shift/saturate of the running sum (optional ReLU via DENSE_RELU_EN)
module dense_mac
    import dense_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int W_W   = 16,
    parameter int OUT_W = 32,
    parameter int FRAC  = 8,
    parameter int ACC_W = 52
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic signed [IN_W-1:0]  x_i,
    input  logic signed [W_W-1:0]   w_i,
    output logic signed [ACC_W-1:0] sum_o,
    output logic signed [OUT_W-1:0] res_o
);

    logic signed [IN_W+W_W-1:0] prod;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [127:0]        sat;

    // Product, new sum, then floor-shift and clamp into the output range.
    always_comb begin
        prod    = x_i * w_i;
        sum_o   = acc_i + ACC_W'(prod);
        shifted = sum_o >>> FRAC;
        sat     = saturate(128'(shifted), OUT_W);
`ifdef DENSE_RELU_EN
        res_o   = sat < 128'sd0 ? '0 : OUT_W'(sat);
`else
        res_o   = OUT_W'(sat);
`endif
    end

endmodule

// File: rtl/dense_layer.sv
// dense_layer: sequential fully-connected layer, one MAC per cycle; DENSE_RELU_EN enables ReLU on outputs
module dense_layer
    import dense_pkg::*;
#(
    parameter int IN_W    = 32,
    parameter int IN_DIM  = 4,
    parameter int OUT_W   = 32,
    parameter int OUT_DIM = 4,
    parameter int W_W     = 16,
    parameter int FRAC    = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic signed [IN_W-1:0]                in_data [0:IN_DIM-1],
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic signed [OUT_W-1:0]               out_data [0:OUT_DIM-1],
    output logic                                  out_ready,
    input  logic                                  w_wr_en,
    input  logic [$clog2(OUT_DIM*(IN_DIM+1))-1:0] w_addr,
    input  logic signed [W_W-1:0]                 w_data
);

    localparam int ACC_W = acc_width(IN_W, W_W, IN_DIM);
    localparam int NC    = OUT_DIM * (IN_DIM + 1);
    localparam int AW    = $clog2(NC);
    localparam int IW    = IN_DIM > 1 ? $clog2(IN_DIM) : 1;
    localparam int JW    = OUT_DIM > 1 ? $clog2(OUT_DIM) : 1;

    state_t                  state_q, state_d;
    logic [IW-1:0]           i_q, i_d;
    logic [JW-1:0]           j_q, j_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [IN_W-1:0]  x_q [0:IN_DIM-1];
    logic signed [IN_W-1:0]  x_d [0:IN_DIM-1];
    logic signed [OUT_W-1:0] out_q [0:OUT_DIM-1];
    logic signed [OUT_W-1:0] out_d [0:OUT_DIM-1];
    logic                    rdy_q, rdy_d;
    logic signed [W_W-1:0]   coef_q [0:NC-1];
    logic [AW-1:0]           cidx, bidx;
    logic                    last_i, last_j;
    logic signed [ACC_W-1:0] sum;
    logic signed [OUT_W-1:0] res;

    assign in_ready  = state_q == IDLE;
    assign out_ready = rdy_q;
    assign out_data  = out_q;
    assign last_i    = i_q == IW'(IN_DIM - 1);
    assign last_j    = j_q == JW'(OUT_DIM - 1);
    assign cidx      = AW'(int'(j_q) * (IN_DIM + 1) + int'(i_q));
    assign bidx      = AW'((int'(j_q) + 1) * (IN_DIM + 1) + IN_DIM);

    dense_mac #(
        .IN_W  (IN_W),
        .W_W   (W_W),
        .OUT_W (OUT_W),
        .FRAC  (FRAC),
        .ACC_W (ACC_W)
    ) u_mac (
        .acc_i (acc_q),
        .x_i   (x_q[i_q]),
        .w_i   (coef_q[cidx]),
        .sum_o (sum),
        .res_o (res)
    );

    // Coefficient RAM: writable only while idle, deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en && state_q == IDLE) coef_q[w_addr] <= w_data;
    end

    // Next state: capture and preload bias, then walk i within each neuron j.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        acc_d   = acc_q;
        x_d     = x_q;
        out_d   = out_q;
        rdy_d   = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                x_d     = in_data;
                i_d     = '0;
                j_d     = '0;
                acc_d   = ACC_W'(coef_q[IN_DIM]);
                state_d = MAC;
            end
            MAC: if (last_i) begin
                out_d[j_q] = res;
                i_d        = '0;
                j_d        = j_q + 1'b1;
                acc_d      = last_j ? '0 : ACC_W'(coef_q[bidx]);
                state_d    = last_j ? DONE : MAC;
                rdy_d      = last_j;
            end else begin
                acc_d = sum;
                i_d   = i_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            x_q     <= '{default: '0};
            out_q   <= '{default: '0};
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            out_q   <= out_d;
            rdy_q   <= rdy_d;
        end
    end

endmodule

// File: tb/tb_dense_layer.sv
// tb_dense_layer: directed checks of dense_layer in three small configurations
module tb_dense_layer;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] in_data [0:1];
    logic               va, vb, vc;
    logic               ra, rb, rc;
    logic               ora, orb, orc;
    logic signed [31:0] oa [0:1];
    logic signed [7:0]  ob [0:1];
    logic signed [7:0]  oc [0:1];
    logic               w_wr_en;
    logic [2:0]         w_addr;
    logic signed [7:0]  w_data;
    int                 passed = 0;
    int                 total  = 0;

    always #5 clk = ~clk;

    dense_layer #(.IN_W(16), .IN_DIM(2), .OUT_W(32), .OUT_DIM(2), .W_W(8), .FRAC(0)) dut_a (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(va), .in_ready(ra),
        .out_data(oa), .out_ready(ora), .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data));

    dense_layer #(.IN_W(16), .IN_DIM(2), .OUT_W(8), .OUT_DIM(2), .W_W(8), .FRAC(0)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(vb), .in_ready(rb),
        .out_data(ob), .out_ready(orb), .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data));

    dense_layer #(.IN_W(16), .IN_DIM(2), .OUT_W(8), .OUT_DIM(2), .W_W(8), .FRAC(1)) dut_c (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(vc), .in_ready(rc),
        .out_data(oc), .out_ready(orc), .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data));

    function automatic longint rl(input longint v);
`ifdef DENSE_RELU_EN
        return v < 0 ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wr(input int a, input int d);
        w_wr_en = 1'b1;
        w_addr  = 3'(a);
        w_data  = 8'(d);
        step;
        w_wr_en = 1'b0;
    endtask

    task automatic set_in(input int x0, input int x1);
        in_data[0] = 16'(x0);
        in_data[1] = 16'(x1);
    endtask

    task automatic go_a(input int x0, input int x1);
        set_in(x0, x1);
        va = 1'b1;
        step;
        va = 1'b0;
    endtask

    // Entered in cycle T+1; expects out_ready only at T+5 and idle again at T+6.
    task automatic finish_a(input string tag, input longint e0, input longint e1);
        for (int k = 1; k <= 4; k++) begin
            chk({tag, "_early_rdy"}, ora, 0);
            step;
        end
        chk({tag, "_rdy"}, ora, 1);
        chk({tag, "_out0"}, oa[0], e0);
        chk({tag, "_out1"}, oa[1], e1);
        step;
        chk({tag, "_rdy_drop"}, ora, 0);
        chk({tag, "_idle"}, ra, 1);
    endtask

    initial begin
        reset   = 1'b1;
        va      = 1'b0;
        vb      = 1'b0;
        vc      = 1'b0;
        w_wr_en = 1'b0;
        w_addr  = '0;
        w_data  = '0;
        set_in(0, 0);
        step;
        step;
        reset = 1'b0;
        chk("rst_in_ready", ra, 1);
        chk("rst_out_ready", ora, 0);
        chk("rst_out0", oa[0], 0);
        chk("rst_out1", oa[1], 0);

        wr(0, 1); wr(1, 1); wr(2, 0); wr(3, 1); wr(4, 1); wr(5, 0);
        go_a(3, 4);
        chk("basic_busy", ra, 0);
        finish_a("basic", 7, 7);

        set_in(100, 100);
        vb = 1'b1;
        step;
        vb = 1'b0;
        repeat (4) step;
        chk("sat_rdy", orb, 1);
        chk("sat_out0", ob[0], 127);
        chk("sat_out1", ob[1], 127);
        step;
        set_in(-7, 0);
        vc = 1'b1;
        step;
        vc = 1'b0;
        repeat (4) step;
        chk("shift_rdy", orc, 1);
        chk("shift_out0", oc[0], rl(-4));
        chk("shift_out1", oc[1], rl(-4));
        step;

        wr(0, 2); wr(1, -1); wr(2, 10); wr(3, -3); wr(4, 0); wr(5, 0);
        go_a(5, 4);
        finish_a("sign", 16, rl(-15));

        set_in(5, 4);
        va = 1'b1;
        step;
        set_in(1, 1);
        chk("busy_t1", ra, 0);
        repeat (4) step;
        chk("busy_rdy", ora, 1);
        chk("busy_out0", oa[0], 16);
        chk("busy_out1", oa[1], rl(-15));
        chk("busy_t5", ra, 0);
        step;
        chk("busy_t6_ready", ra, 1);
        step;
        chk("busy_t7_taken", ra, 0);
        va = 1'b0;
        finish_a("busy2", 11, rl(-3));

        go_a(3, 4);
        step;
        reset = 1'b1;
        step;
        reset = 1'b0;
        chk("abort_in_ready", ra, 1);
        chk("abort_out_ready", ora, 0);
        chk("abort_out0", oa[0], 0);
        chk("abort_out1", oa[1], 0);
        for (int k = 0; k < 6; k++) begin
            chk("abort_no_pulse", ora, 0);
            step;
        end
        go_a(5, 4);
        finish_a("post_abort", 16, rl(-15));

        go_a(5, 4);
        wr(2, 50);
        repeat (3) step;
        chk("wgate_rdy", ora, 1);
        chk("wgate_out0", oa[0], 16);
        step;
        go_a(5, 4);
        finish_a("wgate_rb", 16, rl(-15));

        set_in(5, 4);
        va      = 1'b1;
        w_wr_en = 1'b1;
        w_addr  = 3'd2;
        w_data  = 8'sd0;
        step;
        va      = 1'b0;
        w_wr_en = 1'b0;
        finish_a("same_cyc", 16, rl(-15));
        go_a(5, 4);
        finish_a("same_rb", 6, rl(-15));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dense_layer.md
DENSE_LAYER -- requirements
Module: dense_layer

Interface
REQ-001 SHALL have parameter IN_W, default 32: signed input element width.
REQ-002 SHALL have parameter IN_DIM, default 4: input vector length.
REQ-003 SHALL have parameter OUT_W, default 32: signed output element width.
REQ-004 SHALL have parameter OUT_DIM, default 4: output vector length (neuron count).
REQ-005 SHALL have parameter W_W, default 16: signed weight and bias width.
REQ-006 SHALL have parameter FRAC, default 8: fractional bits removed from the accumulator before output.
REQ-007 SHALL have port clk, input, 1: sole clock; all logic on the rising edge.
REQ-008 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port in_data, input, IN_W x [0:IN_DIM-1] unpacked: input vector.
REQ-010 SHALL have port in_valid, input, 1: input vector present.
REQ-011 SHALL have port in_ready, output, 1: block idle and accepting.
REQ-012 SHALL have port out_data, output reg, OUT_W x [0:OUT_DIM-1] unpacked: result vector.
REQ-013 SHALL have port out_ready, output reg, 1: one-cycle pulse when out_data is updated.
REQ-014 SHALL have ports w_wr_en (1), w_addr (clog2(OUT_DIM*(IN_DIM+1))), w_data (W_W), inputs: coefficient write; address j*(IN_DIM+1)+i is weight w[j][i] for i<IN_DIM, and i=IN_DIM is bias b[j].

Function
REQ-015 SHALL implement states IDLE, MAC, DONE; in_ready = (state==IDLE).
REQ-016 SHALL capture in_data into an internal vector register when in_valid && in_ready (cycle T), clear i,j, load acc with b[0], and go to MAC.
REQ-017 SHALL perform one product per MAC cycle: acc += x[i]*w[j][i], signed, i incrementing 0..IN_DIM-1.
REQ-018 SHALL, on the cycle with i==IN_DIM-1, write result(acc+product) into out_data[j], reload acc with b[j+1], and reset i to 0 and increment j.
REQ-019 SHALL go to DONE after the last product of neuron OUT_DIM-1, assert out_ready for exactly one cycle in DONE (cycle T+IN_DIM*OUT_DIM+1), then return to IDLE.
REQ-020 SHALL use accumulator width ACC_W = IN_W+W_W+clog2(IN_DIM+1)+1; no accumulator overflow is possible.
REQ-021 SHALL form result as acc arithmetically shifted right by FRAC (truncation toward minus infinity), saturated to the signed OUT_W range.
REQ-022 SHALL ignore in_valid while not IDLE; inputs are not queued.
REQ-023 SHALL ignore w_wr_en while not IDLE; writes in IDLE take effect the next cycle, and in_valid accepted in the same cycle uses the pre-write coefficient.
REQ-024 SHALL hold out_data stable between out_ready pulses; intermediate neuron updates are visible during MAC.

Reset
REQ-025 SHALL, on reset, set state IDLE, out_ready 0, all out_data 0, and clear acc, i, j, and the input register, aborting any operation with no out_ready pulse.
REQ-026 SHALL not reset coefficient storage; it retains prior contents and its power-up value is undefined.

Configuration
REQ-027 SHALL, when DENSE_RELU_EN is defined, clamp negative results to 0 after saturation; when it is undefined, pass signed saturated results unchanged.

Structure
REQ-028 SHALL place the state enum, an ACC_W width function, and the signed saturate function in package dense_pkg.
REQ-029 SHALL implement multiply, accumulate, shift, and saturate in sub-module dense_mac; the FSM and storage remain in dense_layer.

Verification (IN_DIM=2, OUT_DIM=2, FRAC=0, W_W=8, unless stated)
REQ-030 SHALL test basic operation: all weights 1, biases 0, in_data={3,4} accepted at T -> out_data={7,7}, out_ready high only at T+5.
REQ-031 SHALL test bias and sign: w[0]={2,-1}, b[0]=10, w[1]={-3,0}, b[1]=0, in={5,4} -> out_data={16,-15} without the macro, {16,0} with DENSE_RELU_EN.
REQ-032 SHALL test saturation and shift: OUT_W=8, weights 1, in={100,100} -> out_data[j]=127; with FRAC=1 and in={-7,0} -> out_data[j]=-4.
REQ-033 SHALL test busy handling: in_valid held high through an operation with in_data changed at T+1 -> result reflects the T sample only, and the next acceptance occurs at T+6.
REQ-034 SHALL test reset mid-operation: reset at T+2 -> no out_ready pulse, out_data=0, in_ready=1 next cycle, and a subsequent operation gives the correct result with the retained coefficients.
REQ-035 SHALL test write gating: w_wr_en at T+1 -> ignored, and a readback via a new operation shows the old coefficient.
